map_table: RTL and testbench

Register rename map table for the R10K-style pipeline. Holds the current architectural-to-physical mapping and a per-entry ready ("plus") bit. At dispatch it:
- supplies source tags T1/T2 with ready status;
- supplies the displaced destination tag T_old for the ROB;
- installs the new tag `free_reg` popped from the Free_List.

It sits between decode and the Free_List/ROB/RS, snoops the CDB to set ready bits, and is restored wholesale from the architectural map on rollback.

---
 rtl/map_table_pkg.sv | 17 +
 rtl/map_table_if.sv | 32 +++
 rtl/map_table_entry.sv | 50 +++++
 rtl/map_table.sv | 47 ++++
 tb/tb_map_table.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/map_table_pkg.sv
// Shared widths and types for the rename map table.
package map_table_pkg;

  localparam int unsigned NUM_GEN_REG  = 32;
  localparam int unsigned NUM_PHYS_REG = 64;
  localparam int unsigned PHYS_REG_W   = $clog2(NUM_PHYS_REG);
  localparam int unsigned GEN_REG_W    = $clog2(NUM_GEN_REG);

  typedef logic [PHYS_REG_W-1:0] phys_reg_t;
  typedef logic [GEN_REG_W-1:0]  gen_reg_t;

  // A source is available if its entry is already ready or the CDB completes it this cycle.
  function automatic logic tag_ready(logic rdy, logic cdb_en, phys_reg_t cdb_tag, phys_reg_t tag);
    return rdy | (cdb_en & (cdb_tag == tag));
  endfunction

endpackage

// File: rtl/map_table_if.sv
// Dispatch, CDB and rollback bundle between the rename stage and the map table.
interface map_table_if;
  import map_table_pkg::*;

  logic                          dispatch_en;
  gen_reg_t                      dest_idx;
  phys_reg_t                     free_reg;
  gen_reg_t                      rs1_idx;
  gen_reg_t                      rs2_idx;
  logic                          cdb_en;
  phys_reg_t                     cdb_tag;
  logic                          rollback_en;
  phys_reg_t [NUM_GEN_REG-1:0]   arch_map;
  phys_reg_t                     T1;
  phys_reg_t                     T2;
  logic                          T1_ready;
  logic                          T2_ready;
  phys_reg_t                     T_old;

  modport master (
    output dispatch_en, dest_idx, free_reg, rs1_idx, rs2_idx,
           cdb_en, cdb_tag, rollback_en, arch_map,
    input  T1, T2, T1_ready, T2_ready, T_old
  );

  modport slave (
    input  dispatch_en, dest_idx, free_reg, rs1_idx, rs2_idx,
           cdb_en, cdb_tag, rollback_en, arch_map,
    output T1, T2, T1_ready, T2_ready, T_old
  );

endinterface

// File: rtl/map_table_entry.sv
// One architectural register's mapping: tag plus ready bit,
// updated with rollback > dispatch write > CDB priority.
module map_table_entry
  import map_table_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  phys_reg_t rst_tag_i,
  input  logic      rollback_i,
  input  phys_reg_t arch_tag_i,
  input  logic      wr_en_i,
  input  phys_reg_t wr_tag_i,
  input  logic      cdb_en_i,
  input  phys_reg_t cdb_tag_i,
  output phys_reg_t tag_o,
  output logic      ready_o
);

  phys_reg_t tag_q, tag_d;
  logic      ready_q, ready_d;

  always_comb begin
    tag_d   = tag_q;
    ready_d = ready_q;
    if (rollback_i) begin
      tag_d   = arch_tag_i;
      ready_d = 1'b1;
    end else if (wr_en_i) begin
      // A fresh destination is never ready, whatever the CDB carries this cycle.
      tag_d   = wr_tag_i;
      ready_d = 1'b0;
    end else if (cdb_en_i && (cdb_tag_i == tag_q)) begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_q   <= rst_tag_i;
      ready_q <= 1'b1;
    end else begin
      tag_q   <= tag_d;
      ready_q <= ready_d;
    end
  end

  assign tag_o   = tag_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/map_table.sv
// Register rename map table: combinational source/old-dest lookup with CDB
// ready bypass over an array of map_table_entry registers.
module map_table
  import map_table_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  map_table_if.slave    bus
);

  phys_reg_t                tags   [NUM_GEN_REG];
  logic [NUM_GEN_REG-1:0]   readys;
  logic [NUM_GEN_REG-1:0]   wr_en;

  // Entry 0 ($zero) is left out of the write decode.
  always_comb begin
    wr_en = '0;
    for (int unsigned i = 1; i < NUM_GEN_REG; i++) begin
      wr_en[i] = bus.dispatch_en && (bus.dest_idx == gen_reg_t'(i));
    end
  end

  for (genvar g = 0; g < NUM_GEN_REG; g++) begin : g_entry
    map_table_entry u_entry (
      .clock      (clock),
      .reset      (reset),
      .rst_tag_i  (phys_reg_t'(g)),
      .rollback_i (bus.rollback_en),
      .arch_tag_i (bus.arch_map[g]),
      .wr_en_i    (wr_en[g]),
      .wr_tag_i   (bus.free_reg),
      .cdb_en_i   (bus.cdb_en),
      .cdb_tag_i  (bus.cdb_tag),
      .tag_o      (tags[g]),
      .ready_o    (readys[g])
    );
  end

  always_comb begin
    bus.T1       = tags[bus.rs1_idx];
    bus.T2       = tags[bus.rs2_idx];
    bus.T_old    = tags[bus.dest_idx];
    bus.T1_ready = tag_ready(readys[bus.rs1_idx], bus.cdb_en, bus.cdb_tag, tags[bus.rs1_idx]);
    bus.T2_ready = tag_ready(readys[bus.rs2_idx], bus.cdb_en, bus.cdb_tag, tags[bus.rs2_idx]);
  end

endmodule

// File: tb/tb_map_table.sv
// Directed plus randomized checks of the rename map table against a reference map model.
module tb_map_table;
  import map_table_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  map_table_if bus ();

  map_table dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string     tag;
    phys_reg_t t1;
    phys_reg_t t2;
    phys_reg_t told;
    logic      r1;
    logic      r2;
  } exp_t;

  exp_t      sb[$];
  phys_reg_t m   [NUM_GEN_REG];
  logic      rdy [NUM_GEN_REG];
  int        npass  = 0;
  int        nfail  = 0;
  int        ntotal = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NUM_GEN_REG); i++) begin
      m[i]   = phys_reg_t'(i);
      rdy[i] = 1'b1;
    end
  endtask

  // Clock-edge behaviour of the map, applied with the inputs held across the edge.
  task automatic model_update();
    if (bus.rollback_en) begin
      for (int i = 0; i < int'(NUM_GEN_REG); i++) begin
        m[i]   = bus.arch_map[i];
        rdy[i] = 1'b1;
      end
    end else begin
      if (bus.cdb_en)
        for (int i = 0; i < int'(NUM_GEN_REG); i++)
          if (m[i] == bus.cdb_tag) rdy[i] = 1'b1;
      if (bus.dispatch_en && bus.dest_idx != '0) begin
        m[bus.dest_idx]   = bus.free_reg;
        rdy[bus.dest_idx] = 1'b0;
      end
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag  = tag;
    e.t1   = m[bus.rs1_idx];
    e.t2   = m[bus.rs2_idx];
    e.told = m[bus.dest_idx];
    e.r1   = rdy[bus.rs1_idx] | (bus.cdb_en & (bus.cdb_tag == m[bus.rs1_idx]));
    e.r2   = rdy[bus.rs2_idx] | (bus.cdb_en & (bus.cdb_tag == m[bus.rs2_idx]));
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 8'd0, 8'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".T1"},       8'(bus.T1),       8'(e.t1));
    chk({e.tag, ".T2"},       8'(bus.T2),       8'(e.t2));
    chk({e.tag, ".T_old"},    8'(bus.T_old),    8'(e.told));
    chk({e.tag, ".T1_ready"}, 8'(bus.T1_ready), 8'(e.r1));
    chk({e.tag, ".T2_ready"}, 8'(bus.T2_ready), 8'(e.r2));
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic cyc(input string tag);
    push_exp(tag);
    #3;
    check_out();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic drive(input logic de, input int dst, input int fr,
                       input int r1, input int r2,
                       input logic ce, input int ct, input logic rb);
    bus.dispatch_en = de;
    bus.dest_idx    = gen_reg_t'(dst);
    bus.free_reg    = phys_reg_t'(fr);
    bus.rs1_idx     = gen_reg_t'(r1);
    bus.rs2_idx     = gen_reg_t'(r2);
    bus.cdb_en      = ce;
    bus.cdb_tag     = phys_reg_t'(ct);
    bus.rollback_en = rb;
  endtask

  initial begin
    for (int i = 0; i < int'(NUM_GEN_REG); i++) bus.arch_map[i] = phys_reg_t'(i);
    drive(1'b0, 7, 0, 5, 31, 1'b0, 0, 1'b0);
    model_reset();

    #1 rst_n = 1'b0;
    #1;
    push_exp("reset");
    check_out();
    chk("reset_T1_const",    8'(bus.T1),    8'd5);
    chk("reset_T2_const",    8'(bus.T2),    8'd31);
    chk("reset_Told_const",  8'(bus.T_old), 8'd7);
    chk("reset_rdy_const",   8'({bus.T1_ready, bus.T2_ready}), 8'd3);
    #1 rst_n = 1'b1;
    @(posedge clk);
    model_update();
    #1;

    cyc("idle");

    drive(1'b1, 3, 40, 3, 5, 1'b0, 0, 1'b0);
    cyc("disp3_40");

    drive(1'b0, 0, 0, 3, 5, 1'b1, 40, 1'b0);
    #1;
    chk("cdb40_T1_const",     8'(bus.T1),       8'd40);
    chk("cdb40_bypass_const", 8'(bus.T1_ready), 8'd1);
    cyc("cdb40_bypass");

    drive(1'b0, 0, 0, 3, 5, 1'b0, 0, 1'b0);
    #1;
    chk("rdy3_set_const", 8'(bus.T1_ready), 8'd1);
    cyc("rdy3_set");

    drive(1'b1, 3, 41, 3, 5, 1'b0, 0, 1'b0);
    #1;
    chk("disp3_41_Told_const", 8'(bus.T_old), 8'd40);
    cyc("disp3_41");

    drive(1'b1, 3, 42, 3, 5, 1'b0, 0, 1'b0);
    #1;
    chk("b2b_Told_const", 8'(bus.T_old), 8'd41);
    chk("b2b_T1rdy_const", 8'(bus.T1_ready), 8'd0);
    cyc("disp3_42_b2b");

    drive(1'b1, 0, 45, 0, 3, 1'b0, 0, 1'b0);
    cyc("disp0_45");
    drive(1'b0, 0, 0, 0, 3, 1'b0, 0, 1'b0);
    #1;
    chk("zero_T1_const",  8'(bus.T1),       8'd0);
    chk("zero_rdy_const", 8'(bus.T1_ready), 8'd1);
    cyc("after_disp0");

    drive(1'b1, 4, 50, 4, 3, 1'b1, 4, 1'b0);
    cyc("disp4_cdb4");
    drive(1'b0, 0, 0, 4, 3, 1'b0, 0, 1'b0);
    #1;
    chk("disp_wins_T1_const",  8'(bus.T1),       8'd50);
    chk("disp_wins_rdy_const", 8'(bus.T1_ready), 8'd0);
    cyc("after_disp4");

    drive(1'b1, 10, 51, 4, 10, 1'b1, 50, 1'b0);
    cyc("disp10_cdb50");
    drive(1'b1, 11, 52, 10, 11, 1'b1, 51, 1'b0);
    cyc("disp11_cdb51");

    for (int i = 0; i < int'(NUM_GEN_REG); i++) bus.arch_map[i] = phys_reg_t'(i);
    bus.arch_map[3] = phys_reg_t'(40);
    drive(1'b1, 3, 60, 3, 10, 1'b1, 52, 1'b1);
    cyc("rollback");
    drive(1'b0, 11, 0, 3, 10, 1'b0, 0, 1'b0);
    #1;
    chk("rb_T1_const",   8'(bus.T1),    8'd40);
    chk("rb_T2_const",   8'(bus.T2),    8'd10);
    chk("rb_Told_const", 8'(bus.T_old), 8'd11);
    chk("rb_rdy_const",  8'({bus.T1_ready, bus.T2_ready}), 8'd3);
    cyc("after_rollback");

    for (int n = 0; n < 60; n++) begin
      logic rb;
      rb = ($urandom_range(0, 9) == 0);
      if (rb) begin
        bus.arch_map[0] = '0;
        for (int i = 1; i < int'(NUM_GEN_REG); i++)
          bus.arch_map[i] = phys_reg_t'($urandom_range(0, NUM_PHYS_REG - 1));
      end
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
            int'($urandom_range(32, 63)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            int'(m[$urandom_range(0, 31)]), rb);
      cyc("random");
    end

    drive(1'b1, 9, 55, 3, 10, 1'b1, 40, 1'b0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    push_exp("mid_reset");
    check_out();
    chk("mid_reset_T1_const",   8'(bus.T1),    8'd3);
    chk("mid_reset_Told_const", 8'(bus.T_old), 8'd9);
    #1 rst_n = 1'b1;
    @(posedge clk);
    model_update();
    #1;
    drive(1'b0, 9, 0, 9, 0, 1'b0, 0, 1'b0);
    cyc("post_reset");
    cyc("post_reset2");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
